bip_fetch_decode: RTL and testbench
===================================

Name: bip_fetch_decode

Overview:
- Fetch/decode control stage that sits directly upstream of the 16-bit program memory.
- Drives the program memory address from an internal program counter (PC) and captures the returned instruction word into an instruction register (IR).
- Decodes the 5-bit opcode into accumulator, datapath-mux and data-RAM control strobes for the BIP-style execute datapath.
- Tracks run/halt state and counts retired instructions.

Parameters:
- AB, 11, program address width; also the operand field width.
- DB, 16, instruction width. Instruction layout: opcode = Data[DB-1:AB], operand = Data[AB-1:0].
- CW, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  run request; sampled on clk.
- en  in  1  global advance enable; low freezes every register.
- Data  in  DB  instruction word from program memory (combinational read of Addr).
- Addr  out  AB  program memory address; equals PC.
- Operand  out  AB  IR[AB-1:0].
- WrAcc  out  1  accumulator write strobe.
- SelA  out  2  accumulator source: 00 data RAM, 01 immediate, 10 ALU.
- SelB  out  1  ALU B operand: 0 data RAM, 1 immediate.
- Op  out  1  ALU operation: 0 add, 1 subtract.
- WrRam  out  1  data RAM write strobe.
- RdRam  out  1  data RAM read strobe.
- running  out  1  state == RUN.
- halted  out  1  state == HALT.
- illegal  out  1  the current decoded opcode is unassigned.
- instr_count  out  CW  number of retired instructions; saturating.

Behaviour:
- Reset (async, immediate):
  - state = IDLE; PC = 0; IR = 0; ir_valid = 0; instr_count = 0.
  - All strobes and Sel/Op outputs = 0.
- States: IDLE, RUN, HALT.
  - IDLE -> RUN at an edge with start=1 and en=1.
  - RUN -> HALT at an edge where the decoded instruction is HLT and en=1.
  - HALT -> RUN at an edge with start=1 and en=1. On this edge PC <= 0, instr_count <= 0, ir_valid <= 0.
  - start is ignored while in RUN.
- Pipeline in RUN with en=1, at each edge:
  - IR <= Data; ir_valid <= 1; PC <= PC+1.
  - Fetch-to-decode latency is 1 cycle: the word at address A drives the decode outputs in the cycle after Addr=A.
- PC wrap: PC increments from 2^AB-1 to 0 with no flag.
- Decode outputs:
  - Outputs are combinational from IR, and are gated to all-0 unless state==RUN and ir_valid=1 and en=1.
  - Opcode map:
    - 00000 HLT: no strobes.
    - 00001 STO: WrRam.
    - 00010 LD: RdRam, WrAcc, SelA=00.
    - 00011 LDI: WrAcc, SelA=01.
    - 00100 ADD: RdRam, WrAcc, SelA=10, SelB=0, Op=0.
    - 00101 ADDI: WrAcc, SelA=10, SelB=1, Op=0.
    - 00110 SUB: RdRam, WrAcc, SelA=10, SelB=0, Op=1.
    - 00111 SUBI: WrAcc, SelA=10, SelB=1, Op=1.
  - Opcodes 01000..11111: illegal=1, all other strobes 0, treated as NOP (retired, execution continues).
- HLT handling:
  - In the HLT decode cycle, the concurrent fetch is discarded: ir_valid <= 0 and PC does not increment.
  - PC therefore freezes at HLT address + 1 while halted.
- Retire count: instr_count increments at each edge with state==RUN, ir_valid=1 and en=1, including HLT and illegal opcodes. It saturates at 2^CW-1.
- en=0:
  - PC, IR, ir_valid, state and instr_count all hold.
  - Strobes are forced to 0, so a held instruction is not re-executed.
  - Execution resumes exactly where it stopped when en returns to 1.
- Simultaneous events:
  - rst overrides everything.
  - start together with en=0 is ignored.
  - In HALT, start=1 on the same edge as en=1 restarts the program from address 0.
- Reset mid-RUN: all outputs return to 0 immediately, with no clock edge required; any instruction in flight is dropped.

Test Plan:
1. Reset and idle: assert rst, then release with start=0 -> Addr=0, all strobes 0, running=0, halted=0, instr_count=0, held for 5 cycles.
2. Straight-line program:
   - Memory: 0:0x1805 (LDI 5), 1:0x2803 (ADDI 3), 2:0x0802 (STO 2), 3:0x0000 (HLT). Pulse start.
   - Decode cycle 1: WrAcc=1, SelA=01, Operand=5.
   - Decode cycle 2: WrAcc=1, SelA=10, SelB=1, Op=0, Operand=3.
   - Decode cycle 3: WrRam=1, Operand=2.
   - Then halted=1, Addr frozen at 4, instr_count=4.
3. Freeze: in program 2, hold en=0 for 3 cycles during the ADDI decode -> strobes 0 and Addr=2 throughout. After en returns to 1, the ADDI decode repeats exactly once and the final instr_count=4.
4. Illegal opcode: memory 0:0xF800, 1:0x1801, 2:0x0000 -> illegal=1 for one cycle with all strobes 0. LDI 1 then executes and the block halts with instr_count=3.
5. Wrap-around: AB=4, DB=16, memory filled with 0x1800 (LDI 0) -> Addr steps 15 to 0 with no halt; running stays 1.
6. Async reset and restart:
   - Assert rst between clock edges while in RUN -> outputs 0 and Addr=0 before the next edge.
   - Separately, pulse start in HALT -> PC restarts at 0 and instr_count is cleared to 0.

Source files
------------

// File: rtl/bip_fetch_decode_if.sv
// Program-memory fetch port and decoded execute-control strobes of the BIP fetch/decode stage.
// master = fetch/decode block, slave = program memory plus execute datapath.
interface bip_fetch_decode_if #(
  parameter int AB = 11,
  parameter int DB = 16,
  parameter int CW = 16
);
  logic          start;
  logic          en;
  logic [DB-1:0] Data;
  logic [AB-1:0] Addr;
  logic [AB-1:0] Operand;
  logic          WrAcc;
  logic [1:0]    SelA;
  logic          SelB;
  logic          Op;
  logic          WrRam;
  logic          RdRam;
  logic          running;
  logic          halted;
  logic          illegal;
  logic [CW-1:0] instr_count;

  modport master (
    input  start, en, Data,
    output Addr, Operand, WrAcc, SelA, SelB, Op, WrRam, RdRam,
           running, halted, illegal, instr_count
  );

  modport slave (
    output start, en, Data,
    input  Addr, Operand, WrAcc, SelA, SelB, Op, WrRam, RdRam,
           running, halted, illegal, instr_count
  );
endinterface

// File: rtl/bip_fetch_decode.sv
// BIP fetch/decode stage: PC-driven program fetch into IR, opcode decode into
// accumulator/mux/RAM strobes, IDLE/RUN/HALT control and a saturating retire counter.
module bip_fetch_decode #(
  parameter int AB = 11,
  parameter int DB = 16,
  parameter int CW = 16
) (
  input logic                clk,
  input logic                rst,
  bip_fetch_decode_if.master bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  localparam logic [4:0] OP_HLT  = 5'b00000;
  localparam logic [4:0] OP_STO  = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_LDI  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SUBI = 5'b00111;

  logic [1:0]    state_q, state_d;
  logic [AB-1:0] pc_q, pc_d;
  logic [DB-1:0] ir_q, ir_d;
  logic          ir_valid_q, ir_valid_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The opcode is always the top five instruction bits; any bits between it
  // and the operand field (only present when AB < DB-5) are ignored.
  logic [4:0] opcode;
  logic       active;
  logic       decode_hlt;

  assign opcode     = ir_q[DB-1 -: 5];
  assign active     = (state_q == S_RUN) && ir_valid_q && bus.en;
  assign decode_hlt = active && (opcode == OP_HLT);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    cnt_d      = cnt_q;
    if (bus.en) begin
      case (state_q)
        S_IDLE: if (bus.start) state_d = S_RUN;
        S_RUN: begin
          if (active && (cnt_q != {CW{1'b1}})) cnt_d = cnt_q + 1'b1;
          if (decode_hlt) begin
            // The fetch running alongside HLT is dropped and PC stays put.
            state_d    = S_HALT;
            ir_valid_d = 1'b0;
          end else begin
            ir_d       = bus.Data;
            ir_valid_d = 1'b1;
            pc_d       = pc_q + 1'b1;
          end
        end
        S_HALT: begin
          if (bus.start) begin
            state_d    = S_RUN;
            pc_d       = '0;
            cnt_d      = '0;
            ir_valid_d = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      cnt_q      <= cnt_d;
    end
  end

  logic       wr_acc, sel_b, alu_op, wr_ram, rd_ram, illegal_op;
  logic [1:0] sel_a;

  // Gating with active keeps a frozen or not-yet-valid IR from being executed.
  always_comb begin
    wr_acc     = 1'b0;
    sel_a      = 2'b00;
    sel_b      = 1'b0;
    alu_op     = 1'b0;
    wr_ram     = 1'b0;
    rd_ram     = 1'b0;
    illegal_op = 1'b0;
    if (active) begin
      case (opcode)
        OP_HLT: ;
        OP_STO: wr_ram = 1'b1;
        OP_LD: begin
          rd_ram = 1'b1;
          wr_acc = 1'b1;
        end
        OP_LDI: begin
          wr_acc = 1'b1;
          sel_a  = 2'b01;
        end
        OP_ADD: begin
          rd_ram = 1'b1;
          wr_acc = 1'b1;
          sel_a  = 2'b10;
        end
        OP_ADDI: begin
          wr_acc = 1'b1;
          sel_a  = 2'b10;
          sel_b  = 1'b1;
        end
        OP_SUB: begin
          rd_ram = 1'b1;
          wr_acc = 1'b1;
          sel_a  = 2'b10;
          alu_op = 1'b1;
        end
        OP_SUBI: begin
          wr_acc = 1'b1;
          sel_a  = 2'b10;
          sel_b  = 1'b1;
          alu_op = 1'b1;
        end
        default: illegal_op = 1'b1;
      endcase
    end
  end

  assign bus.Addr        = pc_q;
  assign bus.Operand     = ir_q[AB-1:0];
  assign bus.WrAcc       = wr_acc;
  assign bus.SelA        = sel_a;
  assign bus.SelB        = sel_b;
  assign bus.Op          = alu_op;
  assign bus.WrRam       = wr_ram;
  assign bus.RdRam       = rd_ram;
  assign bus.illegal     = illegal_op;
  assign bus.running     = (state_q == S_RUN);
  assign bus.halted      = (state_q == S_HALT);
  assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_bip_fetch_decode.sv
// Directed self-checking bench for bip_fetch_decode: reset, straight-line program,
// freeze, illegal opcode, PC wrap (4-bit address instance), async reset and restart.
module tb_bip_fetch_decode;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bip_fetch_decode_if #(.AB(11), .DB(16), .CW(16)) bus ();
  bip_fetch_decode_if #(.AB(4),  .DB(16), .CW(16)) bus4 ();

  logic [15:0] mem [0:2047];
  assign bus.Data  = mem[bus.Addr];
  assign bus4.Data = 16'h1800;

  bip_fetch_decode #(.AB(11), .DB(16), .CW(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  bip_fetch_decode #(.AB(4),  .DB(16), .CW(16)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  // {WrAcc, SelA[1:0], SelB, Op, WrRam, RdRam, illegal}
  logic [7:0] strb;
  assign strb = {bus.WrAcc, bus.SelA, bus.SelB, bus.Op, bus.WrRam, bus.RdRam, bus.illegal};

  localparam logic [7:0] ST_NONE = 8'h00;
  localparam logic [7:0] ST_LDI  = 8'hA0;
  localparam logic [7:0] ST_ADDI = 8'hD0;
  localparam logic [7:0] ST_STO  = 8'h04;
  localparam logic [7:0] ST_ILL  = 8'h01;

  int tests = 0;
  int fails = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.en = 1'b1;
    bus4.start = 1'b0;
    bus4.en = 1'b1;
    tick();
    tick();
    #3 rst = 1'b0;
    tick();
  endtask

  task automatic load_prog2;
    mem[0] = 16'h1805;
    mem[1] = 16'h2803;
    mem[2] = 16'h0802;
    mem[3] = 16'h0000;
  endtask

  task automatic start_pulse;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tests++;
      if ({bus.Addr, strb, bus.running, bus.halted} !== '0) begin
        $display("FAIL reset_idle[%0d]: addr=%0d strb=%h run=%b halt=%b expected all 0",
                 i, bus.Addr, strb, bus.running, bus.halted);
        fails++;
      end
      tests++;
      if (bus.instr_count !== 16'd0) begin
        $display("FAIL reset_count[%0d]: got %0d expected 0", i, bus.instr_count);
        fails++;
      end
      tick();
    end
    // start with en=0 must be ignored
    bus.en = 1'b0;
    bus.start = 1'b1;
    tick();
    tests++;
    if (bus.running !== 1'b0) begin
      $display("FAIL start_gated: running=%b expected 0", bus.running);
      fails++;
    end
    bus.start = 1'b0;
    bus.en = 1'b1;
  endtask

  task automatic test_program;
    do_reset();
    load_prog2();
    start_pulse();
    tests++;
    if ({bus.running, bus.Addr, strb} !== {1'b1, 11'd0, ST_NONE}) begin
      $display("FAIL prog_first_run: run=%b addr=%0d strb=%h expected 1/0/00", bus.running, bus.Addr, strb);
      fails++;
    end
    tick();
    tests++;
    if ({strb, bus.Operand, bus.Addr} !== {ST_LDI, 11'd5, 11'd1}) begin
      $display("FAIL prog_ldi: strb=%h opnd=%0d addr=%0d expected a0/5/1", strb, bus.Operand, bus.Addr);
      fails++;
    end
    tick();
    tests++;
    if ({strb, bus.Operand, bus.Addr} !== {ST_ADDI, 11'd3, 11'd2}) begin
      $display("FAIL prog_addi: strb=%h opnd=%0d addr=%0d expected d0/3/2", strb, bus.Operand, bus.Addr);
      fails++;
    end
    tick();
    tests++;
    if ({strb, bus.Operand, bus.Addr} !== {ST_STO, 11'd2, 11'd3}) begin
      $display("FAIL prog_sto: strb=%h opnd=%0d addr=%0d expected 04/2/3", strb, bus.Operand, bus.Addr);
      fails++;
    end
    tick();
    tests++;
    if ({strb, bus.running, bus.Addr} !== {ST_NONE, 1'b1, 11'd4}) begin
      $display("FAIL prog_hlt_decode: strb=%h run=%b addr=%0d expected 00/1/4", strb, bus.running, bus.Addr);
      fails++;
    end
    tick();
    tick();
    tests++;
    if ({bus.halted, bus.running, bus.Addr, bus.instr_count} !== {1'b1, 1'b0, 11'd4, 16'd4}) begin
      $display("FAIL prog_halted: halt=%b run=%b addr=%0d cnt=%0d expected 1/0/4/4",
               bus.halted, bus.running, bus.Addr, bus.instr_count);
      fails++;
    end
  endtask

  task automatic test_freeze;
    do_reset();
    load_prog2();
    start_pulse();
    tick();
    tick();
    bus.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if ({strb, bus.Addr, bus.instr_count} !== {ST_NONE, 11'd2, 16'd1}) begin
        $display("FAIL freeze[%0d]: strb=%h addr=%0d cnt=%0d expected 00/2/1", i, strb, bus.Addr, bus.instr_count);
        fails++;
      end
      tick();
    end
    bus.en = 1'b1;
    #1;
    tests++;
    if ({strb, bus.Operand} !== {ST_ADDI, 11'd3}) begin
      $display("FAIL freeze_resume_addi: strb=%h opnd=%0d expected d0/3", strb, bus.Operand);
      fails++;
    end
    tick();
    tests++;
    if (strb !== ST_STO) begin
      $display("FAIL freeze_resume_sto: strb=%h expected 04", strb);
      fails++;
    end
    tick();
    tick();
    tests++;
    if ({bus.halted, bus.Addr, bus.instr_count} !== {1'b1, 11'd4, 16'd4}) begin
      $display("FAIL freeze_final: halt=%b addr=%0d cnt=%0d expected 1/4/4", bus.halted, bus.Addr, bus.instr_count);
      fails++;
    end
  endtask

  task automatic test_illegal;
    do_reset();
    mem[0] = 16'hF800;
    mem[1] = 16'h1801;
    mem[2] = 16'h0000;
    start_pulse();
    tick();
    tests++;
    if (strb !== ST_ILL) begin
      $display("FAIL illegal_decode: strb=%h expected 01", strb);
      fails++;
    end
    tick();
    tests++;
    if ({strb, bus.Operand} !== {ST_LDI, 11'd1}) begin
      $display("FAIL illegal_then_ldi: strb=%h opnd=%0d expected a0/1", strb, bus.Operand);
      fails++;
    end
    tick();
    tick();
    tests++;
    if ({bus.halted, bus.Addr, bus.instr_count} !== {1'b1, 11'd3, 16'd3}) begin
      $display("FAIL illegal_final: halt=%b addr=%0d cnt=%0d expected 1/3/3", bus.halted, bus.Addr, bus.instr_count);
      fails++;
    end
  endtask

  task automatic test_wrap;
    logic [3:0] exp_addr;
    do_reset();
    bus4.start = 1'b1;
    tick();
    bus4.start = 1'b0;
    exp_addr = 4'd0;
    for (int i = 0; i < 20; i++) begin
      tests++;
      if ({bus4.running, bus4.halted, bus4.Addr} !== {1'b1, 1'b0, exp_addr}) begin
        $display("FAIL wrap[%0d]: run=%b halt=%b addr=%0d expected 1/0/%0d",
                 i, bus4.running, bus4.halted, bus4.Addr, exp_addr);
        fails++;
      end
      if (i > 0) begin
        tests++;
        if ({bus4.WrAcc, bus4.SelA, bus4.illegal} !== 4'b1010) begin
          $display("FAIL wrap_ldi[%0d]: wracc=%b sela=%b ill=%b expected 1/01/0",
                   i, bus4.WrAcc, bus4.SelA, bus4.illegal);
          fails++;
        end
      end
      exp_addr = exp_addr + 4'd1;
      tick();
    end
  endtask

  task automatic test_async_reset;
    do_reset();
    load_prog2();
    start_pulse();
    tick();
    tick();
    tests++;
    if (strb !== ST_ADDI) begin
      $display("FAIL async_pre: strb=%h expected d0", strb);
      fails++;
    end
    #3 rst = 1'b1;
    #1;
    tests++;
    if ({strb, bus.Addr, bus.running, bus.instr_count} !== '0) begin
      $display("FAIL async_reset: strb=%h addr=%0d run=%b cnt=%0d expected all 0",
               strb, bus.Addr, bus.running, bus.instr_count);
      fails++;
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_restart;
    start_pulse();
    repeat (5) tick();
    tests++;
    if ({bus.halted, bus.instr_count} !== {1'b1, 16'd4}) begin
      $display("FAIL restart_pre_halt: halt=%b cnt=%0d expected 1/4", bus.halted, bus.instr_count);
      fails++;
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tests++;
    if ({bus.running, bus.Addr, bus.instr_count, strb} !== {1'b1, 11'd0, 16'd0, ST_NONE}) begin
      $display("FAIL restart: run=%b addr=%0d cnt=%0d strb=%h expected 1/0/0/00",
               bus.running, bus.Addr, bus.instr_count, strb);
      fails++;
    end
    tick();
    tests++;
    if ({strb, bus.Addr} !== {ST_LDI, 11'd1}) begin
      $display("FAIL restart_ldi: strb=%h addr=%0d expected a0/1", strb, bus.Addr);
      fails++;
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
    test_reset();
    test_program();
    test_freeze();
    test_illegal();
    test_wrap();
    test_async_reset();
    test_restart();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
